// File: rtl/dec_pkg.sv
// Shared types and constants for the serial decimal-digit receiver.
package dec_pkg;

    typedef enum logic {ACC, DONE} state_e;

    localparam int DIGIT_W   = 4;
    localparam int DEC_BASE  = 10;
    localparam int MAX_DIGIT = 9;

endpackage

// File: rtl/dec_mac10.sv
// Combinational acc*10 + digit step with saturation, sticky overflow and
// illegal-digit detection.
module dec_mac10
    import dec_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0]       acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               ovf_i,
    output logic [W-1:0]       acc_o,
    output logic               ovf_o,
    output logic               err_o
);

    logic [DIGIT_W-1:0] dig_eff;
    logic [W+3:0]       acc_ext;
    logic [W+3:0]       sum;

    assign err_o   = (digit_i > DIGIT_W'(MAX_DIGIT));
    assign dig_eff = err_o ? '0 : digit_i;
    assign acc_ext = {4'b0000, acc_i};

    // acc*10 as two shifts; W+4 bits holds 10*(2^W-1)+9 without wrapping.
    assign sum   = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, dig_eff};
    assign ovf_o = ovf_i | (sum > {4'b0000, {W{1'b1}}});
    assign acc_o = ovf_o ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/dec_digits_to_bin.sv
// Serial BCD digit receiver: accumulates MS-digit-first into a binary word.
// Define DEC_ONES_CNT_EN to add the saturating count of '1' digits (o_ones).
module dec_digits_to_bin
    import dec_pkg::*;
#(
    parameter int W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               d_valid,
    output logic               d_ready,
    input  logic [DIGIT_W-1:0] d_digit,
    input  logic               d_last,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [W-1:0]       o_value,
    output logic               o_ovf,
    output logic               o_err
`ifdef DEC_ONES_CNT_EN
    ,
    output logic [2:0]         o_ones
`endif
);

    state_e       state_q;
    logic [W-1:0] acc_q;
    logic         ovf_q;
    logic         err_q;
    logic [W-1:0] acc_d;
    logic         ovf_d;
    logic         dig_err;
    logic         accept;

    dec_mac10 #(.W(W)) u_mac (
        .acc_i   (acc_q),
        .digit_i (d_digit),
        .ovf_i   (ovf_q),
        .acc_o   (acc_d),
        .ovf_o   (ovf_d),
        .err_o   (dig_err)
    );

    assign accept = d_valid && (state_q == ACC);

`ifdef DEC_ONES_CNT_EN
    logic [2:0] ones_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if (state_q == DONE) begin
            if (o_ready) ones_q <= '0;
        end else if (accept && (d_digit == DIGIT_W'(1)) && (ones_q != 3'd7)) begin
            ones_q <= ones_q + 3'd1;
        end
    end
    assign o_ones = ones_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        err_q <= err_q | dig_err;
                        if (d_last) state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result regs hold until the consumer takes them.
                    if (o_ready) begin
                        state_q <= ACC;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign d_ready = (state_q == ACC);
    assign o_valid = (state_q == DONE);
    assign o_value = acc_q;
    assign o_ovf   = ovf_q;
    assign o_err   = err_q;

endmodule
